mcif_wr_arb: RTL and testbench
==============================

MCIF_WR_ARB -- requirements
Module: mcif_wr_arb

Interface
REQ-001 SHALL have parameter DW, default 8: bits per channel element.
REQ-002 SHALL have parameter TOUT, default 32: channels per data beat.
REQ-003 SHALL have parameter PD_W, default 2+4+32+DW*TOUT: write-request payload width.
REQ-004 SHALL have parameter RSP_DEPTH, default 4: outstanding non-posted burst slots (power of 2).
REQ-005 SHALL have port clk  in  1  clock.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req0_vld / req1_vld  in  1  requester write-request valid (0 = conv WDMA, 1 = pool WDMA).
REQ-008 SHALL have ports req0_pd / req1_pd  in  PD_W  requester payload.
REQ-009 SHALL have ports req0_rdy / req1_rdy  out  1  requester ready.
REQ-010 SHALL have ports req0_rsp_complete / req1_rsp_complete  out  1  routed completion pulse.
REQ-011 SHALL have port mcif_wr_req_vld  out  1  merged request valid.
REQ-012 SHALL have port mcif_wr_req_pd  out  PD_W  merged payload.
REQ-013 SHALL have port mcif_wr_req_rdy  in  1  MCIF ready.
REQ-014 SHALL have port mcif_wr_rsp_complete  in  1  MCIF completion pulse.
REQ-015 SHALL have port arb_err  out  1  sticky protocol-error flag.

Function
REQ-016 SHALL decode a command beat by pd[PD_W-1]=1: addr=pd[31:0], length=pd[35:32] (beats-1), nonposted=pd[36]; any other beat is a data beat.
REQ-017 SHALL run an FSM with states IDLE, CMD, DATA.
REQ-018 IDLE: eligible requester = vld high, pd is a command beat, and (nonposted=0 or rsp FIFO not full).
REQ-019 IDLE: with both eligible, grant the one not granted last (round-robin, pointer reset to favour req0); grant takes effect combinationally in the same cycle, so IDLE->CMD costs zero cycles.
REQ-020 CMD: forward the granted vld/pd to MCIF, rdy from MCIF to the granted requester only; on a vld&rdy handshake latch length into a beat counter, push the requester ID into the rsp FIFO if nonposted=1, go to DATA.
REQ-021 DATA: pass through the granted requester's beats; count each handshake; on the handshake of beat length+1, return to IDLE and flip the round-robin pointer to the other requester.
REQ-022 Non-granted requester SHALL see rdy=0 throughout; mcif_wr_req_vld SHALL be 0 in IDLE when nothing is eligible; pd is don't-care when vld=0 but SHALL be muxed from the granted requester.
REQ-023 A data beat presented in IDLE SHALL never be granted and SHALL set arb_err; a command beat during DATA SHALL be forwarded as data and set arb_err.
REQ-024 Rsp FIFO: RSP_DEPTH x 1-bit IDs; each mcif_wr_rsp_complete pops the head and pulses the matching reqN_rsp_complete for exactly one cycle, registered (1-cycle latency).
REQ-025 Simultaneous push and pop on a full FIFO SHALL succeed; a completion with the FIFO empty SHALL be dropped and set arb_err.
REQ-026 Beat counter SHALL be 4 bits; length=15 yields 16 data beats with no wrap error.

Reset
REQ-027 On rst_n low: FSM=IDLE, rr pointer=req0, counter=0, FIFO empty, all rdy/rsp_complete/arb_err=0, mcif_wr_req_vld=0.
REQ-028 Reset mid-burst SHALL abandon the burst and discard outstanding IDs; no completion pulse after reset until a new non-posted command is issued.

Structure
REQ-029 Shared package (CNN_defines) SHALL hold the pd field offsets (ADDR_LSB=0, LEN_LSB=32, NP_BIT=36, CMD_FLAG=PD_W-1) and AXI_BURST_LEN.
REQ-030 The completion-ID FIFO SHALL be one sub-module, mcif_rsp_id_fifo.

Verification
REQ-031 req0 alone sends cmd length=3 plus 4 data beats with MCIF rdy=1 -> 5 consecutive MCIF beats, FSM back in IDLE after beat 5.
REQ-032 Both requesters hold cmd vld in the same cycle after reset -> req0 burst completes, then req1 burst, no interleaving; a third contention grants req0.
REQ-033 MCIF rdy toggles 1,0,1,0 during a length=15 burst -> exactly 16 data beats forwarded, other requester's rdy stays 0.
REQ-034 Four non-posted cmds (IDs 0,1,1,0), then four completions -> pulses on req0, req1, req1, req0 in order; a fifth non-posted cmd is held until the first completion.
REQ-035 Data beat on req1 while IDLE, then completion with the FIFO empty -> arb_err=1, no grant, no rsp pulse.
REQ-036 rst_n asserted mid-DATA at beat 2 of 8 -> all outputs 0 next cycle, a fresh burst afterward is arbitrated normally.

Source files
------------

// File: rtl/CNN_defines.sv
// Shared definitions for the MCIF write path: payload field layout and
// the arbiter state encoding.
package CNN_defines;

  // Longest write burst in data beats; the length field holds beats-1.
  localparam int AXI_BURST_LEN = 16;

  // Command-beat field layout (low bits of the payload).
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 32;
  localparam int LEN_LSB  = ADDR_LSB + ADDR_W;
  localparam int LEN_W    = $clog2(AXI_BURST_LEN);
  localparam int NP_BIT   = LEN_LSB + LEN_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // The command flag is always the payload MSB, whatever the payload width.
  function automatic int cmd_flag(input int pd_w);
    return pd_w - 1;
  endfunction

endpackage

// File: rtl/mcif_rsp_id_fifo.sv
// Completion-ID FIFO: remembers which requester issued each outstanding
// non-posted burst and routes completions back as one-cycle pulses.
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module mcif_rsp_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_vld,
  input  logic push_id,
  input  logic pop_vld,
  output logic full,
  output logic drop_err,
  output logic rsp0_complete,
  output logic rsp1_complete
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rsp0_q, rsp0_d;
  logic          rsp1_q, rsp1_d;
  logic          empty, push_ok, pop_ok, head_id;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop_ok   = pop_vld & ~empty;
  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign push_ok  = push_vld & (~full | pop_ok);
  assign drop_err = pop_vld & empty;
  assign head_id  = mem_q[rd_ptr_q];

  assign rsp0_complete = rsp0_q;
  assign rsp1_complete = rsp1_q;

  // Pointer/occupancy update and completion routing from the head entry.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rsp0_d   = pop_ok & ~head_id;
    rsp1_d   = pop_ok & head_id;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every outstanding ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rsp0_q   <= rsp0_d;
      rsp1_q   <= rsp1_d;
    end
  end

  // ID storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/mcif_wr_arb.sv
// Two-requester MCIF write arbiter: round-robin grant per burst (command
// beat plus length+1 data beats), with completion routing for non-posted
// bursts and a sticky protocol-error flag.
module mcif_wr_arb
  import CNN_defines::*;
#(
  parameter int DW        = 8,
  parameter int TOUT      = 32,
  parameter int PD_W      = 2 + 4 + 32 + DW * TOUT,
  parameter int RSP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_vld,
  input  logic [PD_W-1:0] req0_pd,
  output logic            req0_rdy,
  output logic            req0_rsp_complete,
  input  logic            req1_vld,
  input  logic [PD_W-1:0] req1_pd,
  output logic            req1_rdy,
  output logic            req1_rsp_complete,
  output logic            mcif_wr_req_vld,
  output logic [PD_W-1:0] mcif_wr_req_pd,
  input  logic            mcif_wr_req_rdy,
  input  logic            mcif_wr_rsp_complete,
  output logic            arb_err
);

  localparam int CMD_FLAG = cmd_flag(PD_W);

  arb_state_e       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             rr_q, rr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             arb_err_q, arb_err_d;

  logic            fifo_full, fifo_err, push;
  logic            elig0, elig1, any_elig, sel, cur_gnt, fwd_en, cur_vld, hs;
  logic [PD_W-1:0] cur_pd;

  // A requester may start a burst only with a command beat, and a
  // non-posted one only when a completion slot is free.
  assign elig0 = req0_vld & req0_pd[CMD_FLAG] & (~req0_pd[NP_BIT] | ~fifo_full);
  assign elig1 = req1_vld & req1_pd[CMD_FLAG] & (~req1_pd[NP_BIT] | ~fifo_full);

  // Grant selection: combinational in IDLE so a command can pass the same cycle.
  always_comb begin
    any_elig = elig0 | elig1;
    sel      = (elig0 & elig1) ? rr_q : elig1;
    cur_gnt  = (state_q == ST_IDLE) ? sel : gnt_q;
    fwd_en   = (state_q != ST_IDLE) | any_elig;
  end

  assign cur_vld = fwd_en & (cur_gnt ? req1_vld : req0_vld);
  assign cur_pd  = cur_gnt ? req1_pd : req0_pd;
  assign hs      = cur_vld & mcif_wr_req_rdy;

  assign mcif_wr_req_vld = cur_vld;
  assign mcif_wr_req_pd  = cur_pd;
  assign req0_rdy        = fwd_en & ~cur_gnt & mcif_wr_req_rdy;
  assign req1_rdy        = fwd_en &  cur_gnt & mcif_wr_req_rdy;
  assign arb_err         = arb_err_q;

  // Burst sequencing: command handshake loads the beat counter, the last
  // data beat hands priority to the other requester.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    arb_err_d = arb_err_q | fifo_err;
    case (state_q)
      ST_IDLE, ST_CMD: begin
        if ((state_q == ST_IDLE) &&
            ((req0_vld & ~req0_pd[CMD_FLAG]) | (req1_vld & ~req1_pd[CMD_FLAG])))
          arb_err_d = 1'b1;
        if (fwd_en) begin
          gnt_d = cur_gnt;
          if (hs) begin
            cnt_d   = cur_pd[LEN_LSB +: LEN_W];
            push    = cur_pd[NP_BIT];
            state_d = ST_DATA;
          end else begin
            state_d = ST_CMD;
          end
        end
      end
      ST_DATA: begin
        if (cur_vld & cur_pd[CMD_FLAG]) arb_err_d = 1'b1;
        if (hs) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            rr_d    = ~gnt_q;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      rr_q      <= 1'b0;
      cnt_q     <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      arb_err_q <= arb_err_d;
    end
  end

  mcif_rsp_id_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_vld     (push),
    .push_id      (cur_gnt),
    .pop_vld      (mcif_wr_rsp_complete),
    .full         (fifo_full),
    .drop_err     (fifo_err),
    .rsp0_complete(req0_rsp_complete),
    .rsp1_complete(req1_rsp_complete)
  );

endmodule

// File: tb/tb_mcif_wr_arb.sv
// Bench for mcif_wr_arb: a transaction-level model (owner, beats left,
// preference, queue of outstanding IDs) checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_mcif_wr_arb;

  localparam int PDW   = 2 + 4 + 32 + 8 * 32;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req0_vld = 1'b0, req1_vld = 1'b0;
  logic [PDW-1:0] req0_pd = '0, req1_pd = '0;
  logic           req0_rdy, req1_rdy, req0_rsp_complete, req1_rsp_complete;
  logic           mcif_wr_req_vld;
  logic [PDW-1:0] mcif_wr_req_pd;
  logic           mcif_wr_req_rdy = 1'b1;
  logic           mcif_wr_rsp_complete = 1'b0;
  logic           arb_err;

  mcif_wr_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_pd(req0_pd), .req0_rdy(req0_rdy),
    .req0_rsp_complete(req0_rsp_complete),
    .req1_vld(req1_vld), .req1_pd(req1_pd), .req1_rdy(req1_rdy),
    .req1_rsp_complete(req1_rsp_complete),
    .mcif_wr_req_vld(mcif_wr_req_vld), .mcif_wr_req_pd(mcif_wr_req_pd),
    .mcif_wr_req_rdy(mcif_wr_req_rdy), .mcif_wr_rsp_complete(mcif_wr_rsp_complete),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [PDW-1:0] act, input logic [PDW-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int  m_owner, m_left, m_pref;
  bit  m_incmd, m_rsp0, m_rsp1, m_err;
  bit  m_q[$];
  logic [PDW-1:0] pdv [2];
  bit  vv [2];
  bit  el [2];
  int  g, sz;
  bit  e_vld, hs, popped, full, idle_now, data_now, id;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_left = 0; m_pref = 0; m_incmd = 0;
      m_rsp0 = 0; m_rsp1 = 0; m_err = 0; m_q.delete();
    end
    vv[0] = req0_vld; vv[1] = req1_vld;
    pdv[0] = req0_pd; pdv[1] = req1_pd;
    full = (m_q.size() == DEPTH);
    for (int i = 0; i < 2; i++)
      el[i] = vv[i] && pdv[i][PDW-1] && (!pdv[i][36] || !full);
    if (m_owner < 0) g = (el[0] && el[1]) ? m_pref : (el[0] ? 0 : (el[1] ? 1 : -1));
    else             g = m_owner;
    e_vld = (g >= 0) && vv[g];

    chk("m_vld",  mcif_wr_req_vld, e_vld);
    if (e_vld) chk("m_pd", mcif_wr_req_pd, pdv[g]);
    chk("m_rdy0", req0_rdy, (g == 0) && mcif_wr_req_rdy);
    chk("m_rdy1", req1_rdy, (g == 1) && mcif_wr_req_rdy);
    chk("m_rsp0", req0_rsp_complete, m_rsp0);
    chk("m_rsp1", req1_rsp_complete, m_rsp1);
    chk("m_err",  arb_err, m_err);

    if (rst_n) begin
      hs = e_vld && mcif_wr_req_rdy;
      idle_now = (m_owner < 0);
      data_now = (m_owner >= 0) && !m_incmd;
      if (idle_now && ((vv[0] && !pdv[0][PDW-1]) || (vv[1] && !pdv[1][PDW-1]))) m_err = 1;
      if (data_now && e_vld && pdv[g][PDW-1]) m_err = 1;
      sz = m_q.size();
      popped = 0; m_rsp0 = 0; m_rsp1 = 0;
      if (mcif_wr_rsp_complete) begin
        if (sz > 0) begin
          id = m_q.pop_front(); popped = 1;
          m_rsp0 = !id; m_rsp1 = id;
        end else m_err = 1;
      end
      if (!data_now) begin
        if (hs) begin
          m_owner = g; m_incmd = 0;
          m_left = int'(pdv[g][35:32]) + 1;
          if (pdv[g][36] && (sz < DEPTH || popped)) m_q.push_back(g[0]);
        end else if (g >= 0) begin
          m_owner = g; m_incmd = 1;
        end
      end else if (hs) begin
        m_left--;
        if (m_left == 0) begin
          m_pref = 1 - m_owner;
          m_owner = -1;
        end
      end
    end
  end

  // ---------------- observation monitor ----------------
  int hs_n = 0, hs0_n = 0, cyc = 0;
  int hs_cyc[$];
  int grant_q[$];
  int rsp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mcif_wr_req_vld && mcif_wr_req_rdy) begin
      hs_n++;
      hs_cyc.push_back(cyc);
      if (mcif_wr_req_pd[PDW-1]) grant_q.push_back(req1_rdy ? 1 : 0);
    end
    if (req0_vld && req0_rdy) hs0_n++;
    if (req0_rsp_complete) rsp_q.push_back(0);
    if (req1_rsp_complete) rsp_q.push_back(1);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [PDW-1:0] mk_cmd(input logic [3:0] len, input bit np);
    logic [PDW-1:0] v;
    v = '0;
    v[PDW-1] = 1'b1;
    v[36] = np;
    v[35:32] = len;
    v[31:0] = $urandom;
    return v;
  endfunction

  function automatic logic [PDW-1:0] mk_data();
    logic [PDW-1:0] v;
    for (int i = 0; i < PDW - 1; i++) v[i] = 1'($urandom_range(0, 1));
    v[PDW-1] = 1'b0;
    return v;
  endfunction

  task automatic drive(input int r, input logic v, input logic [PDW-1:0] pd);
    if (r == 0) begin req0_vld = v; req0_pd = pd; end
    else        begin req1_vld = v; req1_pd = pd; end
  endtask

  // One full burst from requester r: command then len+1 data beats.
  task automatic burst(input int r, input logic [3:0] len, input bit np);
    int budget, viol;
    bit got, my_rdy, oth_rdy;
    viol = 0;
    @(posedge clk); #1;
    for (int b = 0; b <= int'(len) + 1; b++) begin
      drive(r, 1'b1, (b == 0) ? mk_cmd(len, np) : mk_data());
      got = 0; budget = 0;
      while (!got && budget < 300) begin
        @(negedge clk);
        my_rdy  = (r == 0) ? req0_rdy : req1_rdy;
        oth_rdy = (r == 0) ? req1_rdy : req0_rdy;
        if (b > 0 && oth_rdy) viol++;
        got = my_rdy;
        budget++;
        @(posedge clk); #1;
      end
      chk("burst_beat_taken", got, 1'b1);
      if (!got) begin
        drive(r, 1'b0, '0);
        return;
      end
    end
    drive(r, 1'b0, '0);
    chk("other_rdy_low", viol, 0);
    $display("burst req%0d len=%0d np=%0d done at cycle %0d", r, len, np, cyc);
  endtask

  task automatic complete();
    @(posedge clk); #1; mcif_wr_rsp_complete = 1'b1;
    @(posedge clk); #1; mcif_wr_rsp_complete = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int base, base0, rbase, stop;
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vld", mcif_wr_req_vld, 1'b0);
    chk("rst_err", arb_err, 1'b0);

    // Contention right after reset: req0, then req1, then req0 again.
    fork burst(0, 4'd1, 0); burst(1, 4'd1, 0); join
    fork burst(0, 4'd1, 0); burst(1, 4'd1, 0); join
    #1;
    chk("rr_n",  grant_q.size(), 4);
    chk("rr_g0", grant_q[0], 0);
    chk("rr_g1", grant_q[1], 1);
    chk("rr_g2", grant_q[2], 0);
    chk("rr_g3", grant_q[3], 1);

    // Single requester, length 3: five back-to-back MCIF beats.
    base = hs_n; hs_cyc.delete();
    burst(0, 4'd3, 0);
    chk("t1_beats", hs_n - base, 5);
    chk("t1_span", hs_cyc[hs_cyc.size()-1] - hs_cyc[0], 4);
    @(negedge clk);
    chk("t1_idle_vld", mcif_wr_req_vld, 1'b0);

    // Length 15 with MCIF ready toggling; req1 waits with its command.
    base0 = hs0_n; stop = 0;
    fork
      begin burst(0, 4'd15, 0); stop = 1; end
      begin repeat (3) @(posedge clk); burst(1, 4'd0, 0); end
      begin
        while (!stop) begin @(posedge clk); #1; mcif_wr_req_rdy = ~mcif_wr_req_rdy; end
        mcif_wr_req_rdy = 1'b1;
      end
    join
    #1;
    chk("t3_req0_beats", hs0_n - base0, 17);

    // Four non-posted bursts fill the ID FIFO; the fifth waits for a completion.
    burst(0, 4'd0, 1); burst(1, 4'd0, 1); burst(1, 4'd0, 1); burst(0, 4'd0, 1);
    rsp_q.delete();
    base = hs_n;
    fork
      burst(0, 4'd0, 1);
      begin
        repeat (6) @(posedge clk); #1;
        chk("t4_fifth_held", hs_n - base, 0);
        complete();
      end
    join
    repeat (4) complete();
    repeat (2) @(posedge clk); #1;
    chk("t4_rsp_n", rsp_q.size(), 5);
    chk("t4_rsp0", rsp_q[0], 0);
    chk("t4_rsp1", rsp_q[1], 1);
    chk("t4_rsp2", rsp_q[2], 1);
    chk("t4_rsp3", rsp_q[3], 0);
    chk("t4_rsp4", rsp_q[4], 0);

    // Data beat in IDLE, then a completion with nothing outstanding.
    rbase = rsp_q.size(); base = hs_n;
    @(posedge clk); #1; drive(1, 1'b1, mk_data());
    repeat (2) begin
      @(negedge clk);
      chk("t5_rdy1", req1_rdy, 1'b0);
      chk("t5_vld", mcif_wr_req_vld, 1'b0);
    end
    @(posedge clk); #1; drive(1, 1'b0, '0);
    @(negedge clk);
    chk("t5_err", arb_err, 1'b1);
    complete();
    repeat (2) @(posedge clk); #1;
    chk("t5_no_rsp", rsp_q.size() - rbase, 0);
    chk("t5_no_grant", hs_n - base, 0);

    // Reset in the middle of an 8-beat non-posted burst.
    @(posedge clk); #1; drive(0, 1'b1, mk_cmd(4'd7, 1'b1));
    @(posedge clk); #1; drive(0, 1'b1, mk_data());
    @(posedge clk); #1; drive(0, 1'b1, mk_data());
    @(posedge clk); #2; rst_n = 1'b0; drive(0, 1'b0, '0);
    @(negedge clk);
    chk("t6_vld", mcif_wr_req_vld, 1'b0);
    chk("t6_rdy0", req0_rdy, 1'b0);
    chk("t6_rdy1", req1_rdy, 1'b0);
    chk("t6_rsp0", req0_rsp_complete, 1'b0);
    chk("t6_rsp1", req1_rsp_complete, 1'b0);
    chk("t6_err", arb_err, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rbase = rsp_q.size();
    complete();
    repeat (2) @(posedge clk); #1;
    chk("t6_no_rsp", rsp_q.size() - rbase, 0);
    base = hs_n; grant_q.delete();
    burst(1, 4'd1, 0);
    chk("t6_beats", hs_n - base, 3);
    chk("t6_grant", grant_q[0], 1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
